// File: rtl/wb_sram32_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-SRAM32 controller: FSM state
// encodings, wait-counter width and the counter preload helper.
package wb_sram32_ctrl_pkg;

  // Wait counter must hold the largest preload (15 extra cycles + 1).
  localparam int CNT_W = 5;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_WHOLD = 2'd3;

  // Every strobe phase is one mandatory settle cycle plus the configured
  // extra wait cycles, so the counter is preloaded with extra+1.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned extra);
    wait_load = CNT_W'(extra + 1);
  endfunction

endpackage

// File: rtl/wb_sram32_ctrl_if.sv
// Wishbone classic slave bus bundle between the interconnect and the SRAM
// controller. With WB_SRAM_ERR_EN defined the bundle carries an err line.
interface wb_sram32_ctrl_if;
  logic [31:0] adr;
  logic [31:0] dat_wr;
  logic [31:0] dat_rd;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
`ifdef WB_SRAM_ERR_EN
  logic        err;

  modport master (output adr, dat_wr, sel, we, cyc, stb, input dat_rd, ack, err);
  modport slave  (input adr, dat_wr, sel, we, cyc, stb, output dat_rd, ack, err);
`else
  modport master (output adr, dat_wr, sel, we, cyc, stb, input dat_rd, ack);
  modport slave  (input adr, dat_wr, sel, we, cyc, stb, output dat_rd, ack);
`endif
endinterface

// File: rtl/wb_sram32_ctrl_dat_iob.sv
// sram_dat_iob: registered output data, registered tristate enable and a
// read-capture register for the shared 32-bit SRAM data bus.
module sram_dat_iob (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [31:0] dat_i,
  input  logic        drv_set_i,
  input  logic        drv_clr_i,
  input  logic        cap_i,
  inout  wire  [31:0] sram_dat,
  output logic [31:0] rdata_o
);

  logic [31:0] dout_q, dout_d;
  logic [31:0] din_q, din_d;
  logic        drv_q, drv_d;

  // Next-state for output data, drive enable and captured read data.
  always_comb begin
    dout_d = load_i ? dat_i : dout_q;
    din_d  = cap_i ? sram_dat : din_q;
    drv_d  = drv_q;
    if (drv_set_i) drv_d = 1'b1;
    else if (drv_clr_i) drv_d = 1'b0;
  end

  // Pad registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
      din_q  <= '0;
      drv_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      din_q  <= din_d;
      drv_q  <= drv_d;
    end
  end

  assign sram_dat = drv_q ? dout_q : 32'bz;
  assign rdata_o  = din_q;

endmodule

// File: rtl/wb_sram32_ctrl.sv
// wb_sram32_ctrl: Wishbone slave driving a 32-bit async SRAM built from two
// x16 chips (shared adr/oe/we, per-chip ce_n, ub/lb per chip).
// One access in flight; every SRAM control pin comes straight from a flop.
// Optional macro WB_SRAM_ERR_EN: misaligned or empty-select requests are
// answered with a one-cycle err pulse instead of an SRAM cycle.
module wb_sram32_ctrl
  import wb_sram32_ctrl_pkg::*;
#(
  parameter int adr_width = 18,
  parameter int rd_wait   = 2,
  parameter int wr_wait   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_sram32_ctrl_if.slave      wb,
  output logic [adr_width-1:0] sram_adr,
  inout  wire  [31:0]          sram_dat,
  output logic [3:0]           sram_be_n,
  output logic [1:0]           sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [adr_width-1:0]   adr_q, adr_d;
  logic [3:0]             be_n_q, be_n_d;
  logic [1:0]             ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   ack_q, ack_d;
  logic                   lost_q, lost_d;
  logic                   load, drv_set, drv_clr, cap;
  logic                   req;
  logic [31:0]            rdata;
  logic                   unused_adr;
`ifdef WB_SRAM_ERR_EN
  logic                   err_q, err_d;
  logic                   bad;

  // Misaligned byte address or no byte lanes selected.
  assign bad = (wb.adr[1:0] != 2'b00) || (wb.sel == 4'h0);
  // A pending ack or err response masks the still-asserted strobe.
  assign req = wb.cyc & wb.stb & ~ack_q & ~err_q;
  assign wb.err = err_q;
`else
  assign req = wb.cyc & wb.stb & ~ack_q;
`endif

  // Upper address bits alias; byte-offset bits only matter for err checking.
  assign unused_adr = ^{wb.adr[31:adr_width+2], wb.adr[1:0]};

  // Access sequencer: IDLE -> READ -> IDLE or IDLE -> WRITE -> WHOLD -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    be_n_d  = be_n_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    ack_d   = 1'b0;
    lost_d  = lost_q;
    load    = 1'b0;
    drv_set = 1'b0;
    drv_clr = 1'b0;
    cap     = 1'b0;
`ifdef WB_SRAM_ERR_EN
    err_d   = 1'b0;
`endif
    // Once the master abandons the cycle the SRAM access still finishes,
    // but no acknowledge may be delivered for it.
    if ((state_q != ST_IDLE) && !wb.cyc) lost_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
`ifdef WB_SRAM_ERR_EN
          if (bad) err_d = 1'b1;
          else
`endif
          begin
            adr_d  = wb.adr[adr_width+1:2];
            be_n_d = ~wb.sel;
            ce_n_d = 2'b00;
            lost_d = 1'b0;
            if (wb.we) begin
              we_n_d  = 1'b0;
              load    = 1'b1;
              drv_set = 1'b1;
              cnt_d   = wait_load(wr_wait);
              state_d = ST_WRITE;
            end else begin
              oe_n_d  = 1'b0;
              cnt_d   = wait_load(rd_wait);
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          cap     = 1'b1;
          oe_n_d  = 1'b1;
          ce_n_d  = 2'b11;
          be_n_d  = 4'hF;
          ack_d   = wb.cyc & ~lost_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        // we_n rises first; data, address and chip enables stay put one
        // more cycle to give the chips hold time.
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = ST_WHOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        ce_n_d  = 2'b11;
        be_n_d  = 4'hF;
        drv_clr = 1'b1;
        ack_d   = wb.cyc & ~lost_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and pin registers; reset aborts any access immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      be_n_q  <= 4'hF;
      ce_n_q  <= 2'b11;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      lost_q  <= lost_d;
    end
  end

`ifdef WB_SRAM_ERR_EN
  // Error response flag, one cycle wide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  sram_dat_iob u_iob (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load),
    .dat_i     (wb.dat_wr),
    .drv_set_i (drv_set),
    .drv_clr_i (drv_clr),
    .cap_i     (cap),
    .sram_dat  (sram_dat),
    .rdata_o   (rdata)
  );

  assign wb.ack    = ack_q;
  assign wb.dat_rd = rdata;
  assign sram_adr  = adr_q;
  assign sram_be_n = be_n_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_wb_sram32_ctrl.sv
// Bench for wb_sram32_ctrl: two x16 SRAM models on the pins, a word-level
// reference memory, and a scoreboard queue drained by a monitor process.
module tb_wb_sram32_ctrl;

  localparam int AW  = 18;
  localparam int RDW = 2;
  localparam int WRW = 2;
  localparam int RD_LAT = RDW + 2;
  localparam int WR_LAT = WRW + 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_sram32_ctrl_if wbi ();

  logic [AW-1:0] sram_adr;
  wire  [31:0]   sram_dat;
  logic [3:0]    sram_be_n;
  logic [1:0]    sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  wb_sram32_ctrl #(.adr_width(AW), .rd_wait(RDW), .wr_wait(WRW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wb        (wbi),
    .sram_adr  (sram_adr),
    .sram_dat  (sram_dat),
    .sram_be_n (sram_be_n),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  // Two x16 async SRAM chips: chip 0 on [15:0], chip 1 on [31:16].
  logic [15:0] mem0 [0:(1<<AW)-1];
  logic [15:0] mem1 [0:(1<<AW)-1];
  wire rd0 = !sram_ce_n[0] && !sram_oe_n && sram_we_n;
  wire rd1 = !sram_ce_n[1] && !sram_oe_n && sram_we_n;
  assign sram_dat[15:0]  = rd0 ? mem0[sram_adr] : 16'bz;
  assign sram_dat[31:16] = rd1 ? mem1[sram_adr] : 16'bz;

  always @(negedge clk) begin
    if (!sram_we_n) begin
      if (!sram_ce_n[0] && !sram_be_n[0]) mem0[sram_adr][7:0]  <= sram_dat[7:0];
      if (!sram_ce_n[0] && !sram_be_n[1]) mem0[sram_adr][15:8] <= sram_dat[15:8];
      if (!sram_ce_n[1] && !sram_be_n[2]) mem1[sram_adr][7:0]  <= sram_dat[23:16];
      if (!sram_ce_n[1] && !sram_be_n[3]) mem1[sram_adr][15:8] <= sram_dat[31:24];
    end
  end

  // Scoreboard and reference memory.
  typedef struct packed {
    logic        we;
    logic [31:0] dat;
  } exp_t;

  exp_t          exp_q[$];
  logic [31:0]   ref_mem [int];
  int            checks = 0;
  int            fails  = 0;
  int            acks   = 0;
  logic [AW-1:0] exp_word = '0;
  logic [3:0]    exp_be_n = 4'hF;
  logic [31:0]   exp_wdat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic void ref_wr(input int w, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] cur;
    cur = ref_rd(w);
    for (int b = 0; b < 4; b++)
      if (sel[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[w] = cur;
  endfunction

  // Monitor: pops an expectation for every ack, checks pin behaviour.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (wbi.ack === 1'b1) begin
          acks++;
          chk("ack_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!e.we) chk("rdata", wbi.dat_rd, e.dat);
          end
        end
        if (!sram_oe_n) begin
          chk("rd_we_n_high", 32'(sram_we_n), 32'd1);
          chk("rd_ce_n", 32'(sram_ce_n), 32'd0);
          chk("rd_adr", 32'(sram_adr), 32'(exp_word));
        end
        if (!sram_we_n) begin
          chk("wr_oe_n_high", 32'(sram_oe_n), 32'd1);
          chk("wr_ce_n", 32'(sram_ce_n), 32'd0);
          chk("wr_be_n", 32'(sram_be_n), 32'(exp_be_n));
          chk("wr_adr", 32'(sram_adr), 32'(exp_word));
          chk("wr_dat", sram_dat, exp_wdat);
        end
      end
    end
  end

  task automatic idle_bus();
    @(negedge clk);
    while (wbi.ack === 1'b1) @(negedge clk);
  endtask

  task automatic wait_ack(output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 50 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (wbi.ack === 1'b1) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  // Expectation for a request, pushed as it is issued.
  task automatic expect_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
    exp_t e;
    exp_word = adr[AW+1:2];
    exp_be_n = ~sel;
    exp_wdat = dat;
    if (we) ref_wr(word_of(adr), dat, sel);
    e.we  = we;
    e.dat = we ? 32'h0 : ref_rd(word_of(adr));
    exp_q.push_back(e);
  endtask

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int lat);
    int n;
    idle_bus();
    expect_req(we, adr, dat, sel);
    wbi.adr = adr; wbi.dat_wr = dat; wbi.sel = sel; wbi.we = we;
    wbi.cyc = 1'b1; wbi.stb = 1'b1;
    wait_ack(n);
    wbi.cyc = 1'b0; wbi.stb = 1'b0;
    chk(we ? "wr_latency" : "rd_latency", 32'(n - 1), 32'(lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, a0;
    logic [31:0] adr, hi, lo2;
    logic [3:0]  sel;
    logic [AW-1:0] wv;
    bit we;

    reset_n = 1'b1;
    wbi.adr = '0; wbi.dat_wr = '0; wbi.sel = '0; wbi.we = 1'b0;
    wbi.cyc = 1'b0; wbi.stb = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ack", 32'(wbi.ack), 32'd0);
    chk("rst_dat_o", wbi.dat_rd, 32'd0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd3);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_adr", 32'(sram_adr), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write / read back, plus an aliased read of the same word
    xfer(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, WR_LAT);
    xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, RD_LAT);
    xfer(1'b0, 32'hFFF0_0100, 32'h0, 4'hF, RD_LAT);

    // Byte-lane write
    xfer(1'b1, 32'h0000_0200, 32'h1122_3344, 4'hF, WR_LAT);
    xfer(1'b1, 32'h0000_0200, 32'hAAAA_AAAA, 4'b0010, WR_LAT);
    xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, RD_LAT);

    // Back-to-back reads with stb held across the ack
    idle_bus();
    a0 = acks;
    expect_req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    wbi.adr = 32'h0000_0100; wbi.sel = 4'hF; wbi.we = 1'b0;
    wbi.cyc = 1'b1; wbi.stb = 1'b1;
    wait_ack(n);
    expect_req(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    wbi.adr = 32'h0000_0200;
    wait_ack(n);
    wbi.cyc = 1'b0; wbi.stb = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_ack_count", 32'(acks - a0), 32'd2);

    // cyc dropped during READ: no ack, next request normal
    idle_bus();
    a0 = acks;
    exp_word = 18'h40;
    wbi.adr = 32'h0000_0100; wbi.sel = 4'hF; wbi.we = 1'b0;
    wbi.cyc = 1'b1; wbi.stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wbi.cyc = 1'b0; wbi.stb = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_ack", 32'(acks - a0), 32'd0);
    xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, RD_LAT);

    // Reset during WRITE (word 0xC00 is never read afterwards)
    idle_bus();
    a0 = acks;
    exp_word = 18'hC00; exp_be_n = 4'h0; exp_wdat = 32'h5555_AAAA;
    wbi.adr = 32'h0000_3000; wbi.dat_wr = 32'h5555_AAAA; wbi.sel = 4'hF; wbi.we = 1'b1;
    wbi.cyc = 1'b1; wbi.stb = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("wr_active_before_rst", 32'(sram_we_n), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rstw_we_n", 32'(sram_we_n), 32'd1);
    chk("rstw_ce_n", 32'(sram_ce_n), 32'd3);
    chk("rstw_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rstw_ack", 32'(wbi.ack), 32'd0);
    wbi.cyc = 1'b0; wbi.stb = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstw_no_ack", 32'(acks - a0), 32'd0);
    xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, RD_LAT);

`ifdef WB_SRAM_ERR_EN
    // Misaligned read gets an err pulse and no SRAM cycle
    begin
      int errs, first;
      idle_bus();
      a0 = acks; errs = 0; first = -1;
      wbi.adr = 32'h0000_0102; wbi.sel = 4'hF; wbi.we = 1'b0;
      wbi.cyc = 1'b1; wbi.stb = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk);
        #1;
        if (wbi.err === 1'b1) begin
          errs++;
          if (first < 0) first = k;
          wbi.cyc = 1'b0; wbi.stb = 1'b0;
        end
        chk("err_ce_n_idle", 32'(sram_ce_n), 32'd3);
      end
      wbi.cyc = 1'b0; wbi.stb = 1'b0;
      chk("err_pulses", 32'(errs), 32'd1);
      chk("err_latency", 32'(first), 32'd1);
      chk("err_no_ack", 32'(acks - a0), 32'd0);
    end
`endif

    // Randomized traffic over a 16-word pool with aliased upper address bits
    for (int i = 0; i < 16; i++) begin
      wv = AW'(32'h1000 + i);
      xfer(1'b1, 32'(wv) << 2, $urandom, 4'hF, WR_LAT);
    end
    for (int k = 0; k < 80; k++) begin
      wv  = AW'(32'h1000 + $urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      hi  = $urandom;
      lo2 = $urandom;
`ifdef WB_SRAM_ERR_EN
      if (sel == 4'h0) sel = 4'hF;
      lo2 = 32'h0;
`endif
      adr = (hi << (AW + 2)) | (32'(wv) << 2) | (lo2 & 32'h3);
      xfer(we, adr, $urandom, sel, we ? WR_LAT : RD_LAT);
    end

    repeat (6) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
